// File: rtl/osc_pkg.sv
// Shared encodings for the oscilloscope trigger/capture path.
package osc_pkg;

    localparam int unsigned STATE_W = 3;
    localparam int unsigned MODE_W  = 2;

    // Capture FSM states; the encoding is exported on state_dbg.
    typedef enum logic [STATE_W-1:0] {
        ST_IDLE      = 3'd0,
        ST_PRE_FILL  = 3'd1,
        ST_ARMED     = 3'd2,
        ST_POST_FILL = 3'd3,
        ST_DONE      = 3'd4
    } state_e;

    // Trigger mode codes; code 11 behaves exactly like normal.
    typedef enum logic [MODE_W-1:0] {
        MODE_AUTO       = 2'b00,
        MODE_NORMAL     = 2'b01,
        MODE_SINGLE     = 2'b10,
        MODE_NORMAL_ALT = 2'b11
    } trig_mode_e;

endpackage

// File: rtl/capture_ram.sv
// Simple dual-port sample store: synchronous write, registered read.
module capture_ram
    import osc_pkg::*;
#(
    parameter int unsigned DATA_W = 12,
    parameter int unsigned ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    // Write port; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Registered read port, cleared by reset so rd_data starts at zero.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_data <= '0;
        end else begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/trigger_capture.sv
// Edge-triggered capture of a pre/post-trigger frame into a circular buffer.
module trigger_capture
    import osc_pkg::*;
#(
    parameter int unsigned DATA_W       = 12,
    parameter int unsigned ADDR_W       = 8,
    parameter int unsigned PRE_TRIG     = 64,
    parameter int unsigned AUTO_TIMEOUT = 4096
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     sample_en,
    input  logic signed [DATA_W-1:0] sample_in,
    input  logic signed [DATA_W-1:0] trig_level,
    input  logic                     trig_slope,
    input  logic [MODE_W-1:0]        trig_mode,
    input  logic                     arm,
    input  logic [ADDR_W-1:0]        rd_addr,
    output logic signed [DATA_W-1:0] rd_data,
    output logic                     frame_ready,
    input  logic                     frame_ack,
    output logic                     triggered,
    output logic [STATE_W-1:0]       state_dbg
);

    localparam int unsigned DEPTH    = 2 ** ADDR_W;
    localparam int unsigned POST_CNT = DEPTH - 1 - PRE_TRIG;
    localparam int unsigned PRE_W    = $clog2(PRE_TRIG + 2);
    localparam int unsigned POST_W   = $clog2(POST_CNT + 2);
    localparam int unsigned TO_W     = $clog2(AUTO_TIMEOUT + 2);

    state_e                    state;
    logic [ADDR_W-1:0]         wr_ptr;
    logic [ADDR_W-1:0]         trig_addr;
    logic signed [DATA_W-1:0]  prev_sample;
    logic [PRE_W-1:0]          pre_cnt;
    logic [POST_W-1:0]         post_cnt;
    logic [TO_W-1:0]           to_cnt;

    logic                      capturing_c;
    logic                      rise_c;
    logic                      fall_c;
    logic                      event_c;
    logic                      auto_c;
    logic                      single_c;
    logic                      timeout_c;
    logic [ADDR_W-1:0]         start_addr_c;
    logic [ADDR_W-1:0]         ram_rd_addr_c;
    logic [DATA_W-1:0]         ram_rd_data;

    // Trigger detection, write qualification and frame-relative read address.
    always_comb begin
        capturing_c   = sample_en && ((state == ST_PRE_FILL) ||
                                      (state == ST_ARMED)    ||
                                      (state == ST_POST_FILL));
        rise_c        = (prev_sample < trig_level) && (sample_in >= trig_level);
        fall_c        = (prev_sample > trig_level) && (sample_in <= trig_level);
        event_c       = trig_slope ? fall_c : rise_c;
        auto_c        = (trig_mode == MODE_AUTO);
        single_c      = (trig_mode == MODE_SINGLE);
        timeout_c     = auto_c && (to_cnt >= TO_W'(AUTO_TIMEOUT - 1));
        start_addr_c  = trig_addr - ADDR_W'(PRE_TRIG);
        ram_rd_addr_c = start_addr_c + rd_addr;
    end

    // Capture FSM with write pointer, history sample and phase counters.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            wr_ptr      <= '0;
            trig_addr   <= '0;
            prev_sample <= '0;
            pre_cnt     <= '0;
            post_cnt    <= '0;
            to_cnt      <= '0;
            frame_ready <= 1'b0;
            triggered   <= 1'b0;
        end else begin
            if (capturing_c) begin
                wr_ptr      <= wr_ptr + ADDR_W'(1);
                prev_sample <= sample_in;
            end

            case (state)
                ST_IDLE: begin
                    if (!single_c || arm) begin
                        state   <= ST_PRE_FILL;
                        pre_cnt <= '0;
                    end
                end

                ST_PRE_FILL: begin
                    if (sample_en) begin
                        if (pre_cnt == PRE_W'(PRE_TRIG - 1)) begin
                            state  <= ST_ARMED;
                            to_cnt <= '0;
                        end else begin
                            pre_cnt <= pre_cnt + PRE_W'(1);
                        end
                    end
                end

                ST_ARMED: begin
                    if (sample_en) begin
                        if (event_c || timeout_c) begin
                            trig_addr <= wr_ptr;
                            triggered <= event_c;
                            post_cnt  <= POST_W'(POST_CNT);
                            state     <= ST_POST_FILL;
                        end else if (auto_c) begin
                            to_cnt <= to_cnt + TO_W'(1);
                        end
                    end
                end

                ST_POST_FILL: begin
                    if (sample_en) begin
                        post_cnt <= post_cnt - POST_W'(1);
                        if (post_cnt == POST_W'(1)) begin
                            state       <= ST_DONE;
                            frame_ready <= 1'b1;
                        end
                    end
                end

                ST_DONE: begin
                    if (frame_ack) begin
                        frame_ready <= 1'b0;
                        pre_cnt     <= '0;
                        state       <= single_c ? ST_IDLE : ST_PRE_FILL;
                    end
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign state_dbg = state;
    assign rd_data   = ram_rd_data;

    capture_ram #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (capturing_c),
        .wr_addr (wr_ptr),
        .wr_data (sample_in),
        .rd_addr (ram_rd_addr_c),
        .rd_data (ram_rd_data)
    );

endmodule

// File: tb/tb_trigger_capture.sv
// Directed self-checking bench for trigger_capture.
module tb_trigger_capture;

    logic               clk;
    logic               rst_n;
    logic               sample_en;
    logic signed [11:0] sample_in;
    logic signed [11:0] trig_level;
    logic               trig_slope;
    logic [1:0]         trig_mode;
    logic               arm;
    logic [7:0]         rd_addr;
    logic signed [11:0] rd_data;
    logic               frame_ready;
    logic               frame_ack;
    logic               triggered;
    logic [2:0]         state_dbg;

    int checks;
    int errors;

    trigger_capture dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .sample_en   (sample_en),
        .sample_in   (sample_in),
        .trig_level  (trig_level),
        .trig_slope  (trig_slope),
        .trig_mode   (trig_mode),
        .arm         (arm),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .frame_ready (frame_ready),
        .frame_ack   (frame_ack),
        .triggered   (triggered),
        .state_dbg   (state_dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic send(input int v);
        @(negedge clk);
        sample_en = 1'b1;
        sample_in = 12'(v);
        @(negedge clk);
        sample_en = 1'b0;
    endtask

    task automatic read_at(input int a, output logic signed [11:0] d);
        @(negedge clk);
        rd_addr = 8'(a);
        @(negedge clk);
        d = rd_data;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic ack_frame();
        @(negedge clk);
        frame_ack = 1'b1;
        @(negedge clk);
        frame_ack = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (state_dbg !== 3'd0) begin errors++; $display("FAIL reset_state got %0d exp 0", state_dbg); end
        checks++;
        if (frame_ready !== 1'b0 || triggered !== 1'b0) begin
            errors++; $display("FAIL reset_flags got ready=%0b trig=%0b exp 0 0", frame_ready, triggered);
        end
        checks++;
        if (rd_data !== 12'sd0) begin errors++; $display("FAIL reset_rd_data got %0d exp 0", rd_data); end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (state_dbg !== 3'd1) begin errors++; $display("FAIL reset_exit_prefill got %0d exp 1", state_dbg); end
    endtask

    // Ramp -2048 +16/sample, rising through 0; trigger at sample 128, frame ends at 319.
    task automatic test_rising_ramp();
        logic signed [11:0] d;
        trig_mode = 2'b01; trig_slope = 1'b0; trig_level = 12'sd0;
        do_reset();
        for (int k = 0; k < 320; k++) begin
            send(-2048 + 16 * k);
            if (k == 63 || k == 127) begin
                checks++;
                if (state_dbg !== 3'd2) begin errors++; $display("FAIL ramp_armed k=%0d got %0d exp 2", k, state_dbg); end
            end
            if (k == 128) begin
                checks++;
                if (state_dbg !== 3'd3) begin errors++; $display("FAIL ramp_post got %0d exp 3", state_dbg); end
            end
            if (k == 318) begin
                checks++;
                if (frame_ready !== 1'b0) begin errors++; $display("FAIL ramp_early_ready got %0b exp 0", frame_ready); end
            end
        end
        checks++;
        if (frame_ready !== 1'b1 || triggered !== 1'b1 || state_dbg !== 3'd4) begin
            errors++; $display("FAIL ramp_done got ready=%0b trig=%0b st=%0d exp 1 1 4", frame_ready, triggered, state_dbg);
        end
        read_at(64, d);
        checks++;
        if (d !== 12'sd0) begin errors++; $display("FAIL ramp_rd64 got %0d exp 0", d); end
        read_at(63, d);
        checks++;
        if (d !== -12'sd16) begin errors++; $display("FAIL ramp_rd63 got %0d exp -16", d); end
        read_at(255, d);
        checks++;
        if (d !== -12'sd1040) begin errors++; $display("FAIL ramp_rd255 got %0d exp -1040", d); end
        // Samples in DONE must not overwrite the frame (next slot is rd_addr 0).
        send(777); send(777);
        read_at(0, d);
        checks++;
        if (d !== -12'sd1024) begin errors++; $display("FAIL done_no_write got %0d exp -1024", d); end
        ack_frame();
        checks++;
        if (frame_ready !== 1'b0 || state_dbg !== 3'd1) begin
            errors++; $display("FAIL ack_normal got ready=%0b st=%0d exp 0 1", frame_ready, state_dbg);
        end
    endtask

    task automatic test_auto_timeout();
        trig_mode = 2'b00; trig_slope = 1'b0; trig_level = 12'sd500;
        do_reset();
        for (int i = 1; i <= 4351; i++) begin
            send(100);
            if (i == 64 || i == 4159) begin
                checks++;
                if (state_dbg !== 3'd2) begin errors++; $display("FAIL auto_armed i=%0d got %0d exp 2", i, state_dbg); end
            end
            if (i == 4160) begin
                checks++;
                if (state_dbg !== 3'd3) begin errors++; $display("FAIL auto_forced got %0d exp 3", state_dbg); end
            end
            if (i == 4350) begin
                checks++;
                if (frame_ready !== 1'b0) begin errors++; $display("FAIL auto_early_ready got %0b exp 0", frame_ready); end
            end
        end
        checks++;
        if (frame_ready !== 1'b1 || triggered !== 1'b0) begin
            errors++; $display("FAIL auto_done got ready=%0b trig=%0b exp 1 0", frame_ready, triggered);
        end
    endtask

    task automatic test_normal_no_trigger();
        bit seen_ready;
        seen_ready = 1'b0;
        trig_mode = 2'b01; trig_slope = 1'b0; trig_level = 12'sd500;
        do_reset();
        for (int i = 0; i < 10000; i++) begin
            send(100);
            if (frame_ready === 1'b1) seen_ready = 1'b1;
        end
        checks++;
        if (seen_ready !== 1'b0 || state_dbg !== 3'd2) begin
            errors++; $display("FAIL normal_hold got seen=%0b st=%0d exp 0 2", seen_ready, state_dbg);
        end
    endtask

    task automatic test_single();
        logic signed [11:0] d;
        trig_mode = 2'b10; trig_slope = 1'b0; trig_level = 12'sd0;
        do_reset();
        send(1234);
        checks++;
        if (state_dbg !== 3'd0) begin errors++; $display("FAIL single_idle got %0d exp 0", state_dbg); end
        // RAM is all 100 from the previous test; an IDLE write would land at slot 0.
        read_at(64, d);
        checks++;
        if (d !== 12'sd100) begin errors++; $display("FAIL single_idle_no_write got %0d exp 100", d); end
        @(negedge clk); arm = 1'b1;
        @(negedge clk); arm = 1'b0;
        checks++;
        if (state_dbg !== 3'd1) begin errors++; $display("FAIL single_arm got %0d exp 1", state_dbg); end
        for (int k = 0; k < 320; k++) send(-2048 + 16 * k);
        read_at(64, d);
        checks++;
        if (frame_ready !== 1'b1 || triggered !== 1'b1 || d !== 12'sd0) begin
            errors++; $display("FAIL single_frame got ready=%0b trig=%0b rd64=%0d exp 1 1 0", frame_ready, triggered, d);
        end
        ack_frame();
        checks++;
        if (state_dbg !== 3'd0 || frame_ready !== 1'b0) begin
            errors++; $display("FAIL single_ack got st=%0d ready=%0b exp 0 0", state_dbg, frame_ready);
        end
        send(999);
        read_at(0, d);
        checks++;
        if (state_dbg !== 3'd0 || d !== -12'sd1024) begin
            errors++; $display("FAIL single_rest got st=%0d rd0=%0d exp 0 -1024", state_dbg, d);
        end
        @(negedge clk); arm = 1'b1;
        @(negedge clk); arm = 1'b0;
        checks++;
        if (state_dbg !== 3'd1) begin errors++; $display("FAIL single_rearm got %0d exp 1", state_dbg); end
    endtask

    // Mode 11 behaves as normal; falling edge 1 -> 0 at level 0 must fire.
    task automatic test_falling_equal();
        logic signed [11:0] d;
        trig_mode = 2'b11; trig_slope = 1'b1; trig_level = 12'sd0;
        do_reset();
        for (int i = 0; i < 64; i++) send(5);
        send(1);
        checks++;
        if (state_dbg !== 3'd2) begin errors++; $display("FAIL fall_no_event got %0d exp 2", state_dbg); end
        send(0);
        checks++;
        if (state_dbg !== 3'd3) begin errors++; $display("FAIL fall_equal_event got %0d exp 3", state_dbg); end
        for (int i = 0; i < 191; i++) send(-7);
        checks++;
        if (frame_ready !== 1'b1 || triggered !== 1'b1) begin
            errors++; $display("FAIL fall_done got ready=%0b trig=%0b exp 1 1", frame_ready, triggered);
        end
        read_at(64, d);
        checks++;
        if (d !== 12'sd0) begin errors++; $display("FAIL fall_rd64 got %0d exp 0", d); end
        read_at(63, d);
        checks++;
        if (d !== 12'sd1) begin errors++; $display("FAIL fall_rd63 got %0d exp 1", d); end
        read_at(62, d);
        checks++;
        if (d !== 12'sd5) begin errors++; $display("FAIL fall_rd62 got %0d exp 5", d); end
    endtask

    task automatic test_reset_mid();
        trig_mode = 2'b01; trig_slope = 1'b1; trig_level = 12'sd0;
        do_reset();
        for (int i = 0; i < 64; i++) send(5);
        send(0);
        for (int i = 0; i < 10; i++) send(-3);
        checks++;
        if (state_dbg !== 3'd3) begin errors++; $display("FAIL mid_post got %0d exp 3", state_dbg); end
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if (state_dbg !== 3'd0 || frame_ready !== 1'b0 || triggered !== 1'b0) begin
            errors++; $display("FAIL mid_reset got st=%0d ready=%0b trig=%0b exp 0 0 0", state_dbg, frame_ready, triggered);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (state_dbg !== 3'd1) begin errors++; $display("FAIL mid_restart got %0d exp 1", state_dbg); end
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        rst_n      = 1'b0;
        sample_en  = 1'b0;
        sample_in  = '0;
        trig_level = '0;
        trig_slope = 1'b0;
        trig_mode  = 2'b01;
        arm        = 1'b0;
        rd_addr    = '0;
        frame_ack  = 1'b0;

        test_reset();
        test_rising_ramp();
        test_auto_timeout();
        test_normal_no_trigger();
        test_single();
        test_falling_equal();
        test_reset_mid();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/trigger_capture.md
TRIGGER_CAPTURE -- requirements
Module: trigger_capture

Interface
REQ-001 Parameter DATA_W, default 12: sample width, signed two's complement.
REQ-002 Parameter ADDR_W, default 8: capture depth 2^ADDR_W = 256 samples.
REQ-003 Parameter PRE_TRIG, default 64: samples kept before the trigger sample.
REQ-004 Parameter AUTO_TIMEOUT, default 4096: samples waited in auto mode before a forced trigger.
REQ-005 clk  in  1  single system clock; all logic on its rising edge.
REQ-006 rst_n  in  1  synchronous, active-low reset.
REQ-007 sample_en  in  1  one-cycle strobe marking a new sample.
REQ-008 sample_in  in  12  signed sample from the generator/FIR output.
REQ-009 trig_level  in  12  signed trigger threshold.
REQ-010 trig_slope  in  1  0 = rising, 1 = falling.
REQ-011 trig_mode  in  2  00 auto, 01 normal, 10 single, 11 treated as normal.
REQ-012 arm  in  1  pulse that rearms single mode.
REQ-013 rd_addr  in  8  display read index; 0 = oldest sample of the frame.
REQ-014 rd_data  out  12  signed frame sample.
REQ-015 frame_ready  out  1  a complete frame is held.
REQ-016 frame_ack  in  1  display finished reading the frame.
REQ-017 triggered  out  1  1 = real trigger, 0 = auto-forced frame.
REQ-018 state_dbg  out  3  current state encoding.

Function
REQ-019 States SHALL be IDLE, PRE_FILL, ARMED, POST_FILL and DONE.
REQ-020 In PRE_FILL, ARMED and POST_FILL, each sample_en SHALL write sample_in at wr_ptr, increment wr_ptr modulo 256 and update prev_sample.
REQ-021 No RAM write or prev_sample update SHALL occur in IDLE or DONE.
REQ-022 Rising event SHALL be prev_sample < trig_level AND sample_in >= trig_level; falling event SHALL be prev_sample > trig_level AND sample_in <= trig_level; both are signed compares, evaluated only on sample_en.
REQ-023 IDLE: the FSM SHALL go to PRE_FILL next cycle when trig_mode != 10; when trig_mode = 10 it SHALL wait for arm = 1.
REQ-024 PRE_FILL: the FSM SHALL write PRE_TRIG samples, then enter ARMED; trigger events SHALL be ignored in PRE_FILL.
REQ-025 ARMED, on a sample_en cycle with a trigger event: the FSM SHALL latch trig_addr = wr_ptr, set triggered = 1, load the post counter with 255 - PRE_TRIG and go to POST_FILL.
REQ-026 ARMED, auto mode, no event: the FSM SHALL count samples; on reaching AUTO_TIMEOUT it SHALL force the same transition with triggered = 0; the timeout counter clears on entry to ARMED.
REQ-027 POST_FILL: after 255 - PRE_TRIG further samples (191 at defaults) the FSM SHALL enter DONE and set frame_ready = 1 on the same edge.
REQ-028 The trigger sample SHALL appear at rd_addr = PRE_TRIG; start_addr = (trig_addr - PRE_TRIG) mod 256, held stable in DONE.
REQ-029 rd_data SHALL equal ram[(start_addr + rd_addr) mod 256] registered, with one cycle latency, in every state.
REQ-030 DONE, on frame_ack = 1: frame_ready SHALL clear next cycle; the FSM SHALL go to IDLE if trig_mode = 10, else to PRE_FILL.
REQ-031 frame_ack SHALL be ignored outside DONE; arm SHALL be ignored outside IDLE.
REQ-032 trig_mode and trig_slope SHALL be sampled every cycle; a change takes effect on the next evaluation.
REQ-033 wr_ptr SHALL wrap from 255 to 0 with no pause.

Reset
REQ-034 While rst_n = 0 at a clock edge: state = IDLE; frame_ready = 0; triggered = 0; rd_data = 0; state_dbg = 0; wr_ptr, trig_addr, all counters and prev_sample = 0.
REQ-035 Reset asserted mid-operation SHALL abort the capture; RAM contents are not cleared.

Structure
REQ-036 The state encoding and trig_mode codes SHALL live in shared package osc_pkg.
REQ-037 Sample storage SHALL be sub-module capture_ram: simple dual-port, 256 x 12, synchronous write, registered read.

Verification
REQ-038 Ramp from -2048 in steps of +16 per sample, level 0, rising, normal mode -> frame_ready = 1, triggered = 1, rd_addr 64 reads 0, rd_addr 63 reads -16.
REQ-039 Constant 100, level 500, auto mode -> frame_ready after 64 + 4096 + 191 samples, triggered = 0.
REQ-040 Same stimulus in normal mode -> frame_ready stays 0 for 10000 samples.
REQ-041 Single mode, frame acknowledged -> state IDLE, no writes until an arm pulse, then a new capture completes.
REQ-042 Falling slope, level 0, samples 1 then 0 -> trigger fires (equality boundary).
REQ-043 rst_n low during POST_FILL -> next cycle state_dbg = IDLE, frame_ready = 0.
